// File: rtl/rtc_bus_transactor.sv
// Single-byte read/write transactor for the RTC multiplexed A/D bus (address phase, gap, data phase).
// Optional BCD nibble check on read data is enabled by defining RTC_BCD_CHECK_EN.
module rtc_bus_transactor #(
  parameter int unsigned T_SETUP = 2,
  parameter int unsigned T_PULSE = 4,
  parameter int unsigned T_HOLD  = 2,
  parameter int unsigned T_GAP   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_write,
  input  logic       start_read,
  input  logic [7:0] direccion,
  input  logic [7:0] dato_escritura,
  output logic [7:0] dato_leido,
  output logic       listo_escribe,
  output logic       listo_lee,
  output logic       ocupado,
  output logic       error_bcd,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  input  logic [7:0] ad_in,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       a_d
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned BYTE_W = 8;

  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] LD_PULSE = CNT_W'(T_PULSE - 1);
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] LD_GAP   = CNT_W'(T_GAP - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR_SETUP, S_ADDR_PULSE, S_ADDR_HOLD, S_GAP,
    S_DATA_SETUP, S_DATA_PULSE, S_DATA_HOLD, S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                op_wr_q, op_wr_d;
  logic [BYTE_W-1:0]   addr_q, addr_d;
  logic [BYTE_W-1:0]   data_q, data_d;
  logic [BYTE_W-1:0]   dato_q, dato_d;
  logic                capture;

  logic                cs_n_q, cs_n_d, rd_n_q, rd_n_d, wr_n_q, wr_n_d;
  logic                a_d_q, a_d_d, ad_oe_q, ad_oe_d;
  logic [BYTE_W-1:0]   ad_out_q, ad_out_d;
  logic                le_q, le_d, ll_q, ll_d, occ_q, occ_d;

  // Next-state, operand latching and read capture
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_wr_d = op_wr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    dato_d  = dato_q;
    capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_write || start_read) begin
          op_wr_d = start_write;
          addr_d  = direccion;
          data_d  = dato_escritura;
          state_d = S_ADDR_SETUP;
          cnt_d   = LD_SETUP;
        end
      end
      default: begin
        if (cnt_q == '0) begin
          case (state_q)
            S_ADDR_SETUP: begin state_d = S_ADDR_PULSE; cnt_d = LD_PULSE; end
            S_ADDR_PULSE: begin state_d = S_ADDR_HOLD;  cnt_d = LD_HOLD;  end
            S_ADDR_HOLD:  begin state_d = S_GAP;        cnt_d = LD_GAP;   end
            S_GAP:        begin state_d = S_DATA_SETUP; cnt_d = LD_SETUP; end
            S_DATA_SETUP: begin state_d = S_DATA_PULSE; cnt_d = LD_PULSE; end
            S_DATA_PULSE: begin
              state_d = S_DATA_HOLD;
              cnt_d   = LD_HOLD;
              capture = !op_wr_q;
            end
            S_DATA_HOLD:  begin state_d = S_DONE;       cnt_d = '0;       end
            default:      begin state_d = S_IDLE;       cnt_d = '0;       end
          endcase
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
    endcase
    if (capture) dato_d = ad_in;
  end

  // Bus and status outputs decoded from the state being entered, then registered
  always_comb begin
    cs_n_d   = 1'b1;
    rd_n_d   = 1'b1;
    wr_n_d   = 1'b1;
    a_d_d    = 1'b0;
    ad_oe_d  = 1'b0;
    ad_out_d = '0;
    le_d     = 1'b0;
    ll_d     = 1'b0;
    occ_d    = (state_d != S_IDLE);
    case (state_d)
      S_ADDR_SETUP, S_ADDR_PULSE, S_ADDR_HOLD: begin
        cs_n_d   = 1'b0;
        ad_oe_d  = 1'b1;
        ad_out_d = addr_d;
        wr_n_d   = (state_d != S_ADDR_PULSE);
      end
      S_DATA_SETUP, S_DATA_PULSE, S_DATA_HOLD: begin
        cs_n_d = 1'b0;
        a_d_d  = 1'b1;
        if (op_wr_d) begin
          ad_oe_d  = 1'b1;
          ad_out_d = data_d;
          wr_n_d   = (state_d != S_DATA_PULSE);
        end else begin
          rd_n_d   = (state_d != S_DATA_PULSE);
        end
      end
      S_DONE: begin
        le_d = op_wr_d;
        ll_d = !op_wr_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_wr_q  <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      dato_q   <= '0;
      cs_n_q   <= 1'b1;
      rd_n_q   <= 1'b1;
      wr_n_q   <= 1'b1;
      a_d_q    <= 1'b0;
      ad_oe_q  <= 1'b0;
      ad_out_q <= '0;
      le_q     <= 1'b0;
      ll_q     <= 1'b0;
      occ_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_wr_q  <= op_wr_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      dato_q   <= dato_d;
      cs_n_q   <= cs_n_d;
      rd_n_q   <= rd_n_d;
      wr_n_q   <= wr_n_d;
      a_d_q    <= a_d_d;
      ad_oe_q  <= ad_oe_d;
      ad_out_q <= ad_out_d;
      le_q     <= le_d;
      ll_q     <= ll_d;
      occ_q    <= occ_d;
    end
  end

`ifdef RTC_BCD_CHECK_EN
  logic err_q;

  // Flag read data whose nibbles are not valid BCD digits
  always_ff @(posedge clk) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if (capture) begin
      err_q <= (ad_in[7:4] > 4'd9) || (ad_in[3:0] > 4'd9);
    end
  end

  assign error_bcd = err_q;
`else
  assign error_bcd = 1'b0;
`endif

  assign dato_leido    = dato_q;
  assign listo_escribe = le_q;
  assign listo_lee     = ll_q;
  assign ocupado       = occ_q;
  assign ad_out        = ad_out_q;
  assign ad_oe         = ad_oe_q;
  assign cs_n          = cs_n_q;
  assign rd_n          = rd_n_q;
  assign wr_n          = wr_n_q;
  assign a_d           = a_d_q;

endmodule

// File: tb/tb_rtc_bus_transactor.sv
// Bench for rtc_bus_transactor: default-timing instance plus an all-ones timing instance,
// per-cycle bus trace against a timing model and a completion scoreboard.
module tb_rtc_bus_transactor;

`ifdef RTC_BCD_CHECK_EN
  localparam bit BCD_EN = 1'b1;
`else
  localparam bit BCD_EN = 1'b0;
`endif

  typedef struct {
    bit         sw;
    bit         sr;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] rtc;
    int         poke;
    bit         poke_wr;
    logic [7:0] exp_dato;
    bit         exp_err;
  } vec_t;

  typedef struct {
    bit         is_rd;
    logic [7:0] dato;
    bit         err;
  } sb_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_write, start_read;
  logic [7:0] direccion, dato_escritura, rtc_val;
  bit         sel;

  logic [7:0] dl0, ao0, ai0, dl1, ao1, ai1;
  logic le0, ll0, oc0, eb0, oe0, cs0, rd0, wr0, ad0;
  logic le1, ll1, oc1, eb1, oe1, cs1, rd1, wr1, ad1;

  int n_checks = 0;
  int n_fail   = 0;
  sb_t sb[$];
  vec_t vecs[6];

  always #5 clk = ~clk;

  assign ai0 = rd0 ? 8'hFF : rtc_val;
  assign ai1 = rd1 ? 8'hFF : rtc_val;

  rtc_bus_transactor dut (
    .clk(clk), .reset(reset), .start_write(start_write), .start_read(start_read),
    .direccion(direccion), .dato_escritura(dato_escritura), .dato_leido(dl0),
    .listo_escribe(le0), .listo_lee(ll0), .ocupado(oc0), .error_bcd(eb0),
    .ad_out(ao0), .ad_oe(oe0), .ad_in(ai0), .cs_n(cs0), .rd_n(rd0), .wr_n(wr0), .a_d(ad0)
  );

  rtc_bus_transactor #(.T_SETUP(1), .T_PULSE(1), .T_HOLD(1), .T_GAP(1)) dut_fast (
    .clk(clk), .reset(reset), .start_write(start_write), .start_read(start_read),
    .direccion(direccion), .dato_escritura(dato_escritura), .dato_leido(dl1),
    .listo_escribe(le1), .listo_lee(ll1), .ocupado(oc1), .error_bcd(eb1),
    .ad_out(ao1), .ad_oe(oe1), .ad_in(ai1), .cs_n(cs1), .rd_n(rd1), .wr_n(wr1), .a_d(ad1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] obs_bus();
    if (sel) return {cs1, rd1, wr1, ad1, oe1, oc1, le1, ll1, oe1 ? ao1 : 8'h00};
    return {cs0, rd0, wr0, ad0, oe0, oc0, le0, ll0, oe0 ? ao0 : 8'h00};
  endfunction

  function automatic logic [9:0] obs_status();
    if (sel) return {ll1, dl1, eb1};
    return {ll0, dl0, eb0};
  endfunction

  // Expected {cs_n,rd_n,wr_n,a_d,ad_oe,ocupado,listo_e,listo_l,ad_out} c cycles after acceptance
  function automatic logic [15:0] exp_bus(int c, bit wr, logic [7:0] a, logic [7:0] d,
                                          int s, int p, int h, int g);
    int a1 = s, a2 = s + p, a3 = s + p + h, gg = a3 + g;
    int d1 = gg + s, d2 = d1 + p, d3 = d2 + h, dn = d3 + 1;
    logic cs = 1, rdn = 1, wrn = 1, ad = 0, oe = 0, occ = 1, le = 0, ll = 0;
    logic [7:0] o = 8'h00;
    if (c <= a3) begin
      cs = 0; oe = 1; o = a;
      if (c > a1 && c <= a2) wrn = 0;
    end else if (c <= gg) begin
      cs = 1;
    end else if (c <= d3) begin
      cs = 0; ad = 1;
      if (wr) begin oe = 1; o = d; end
      if (c > d1 && c <= d2) begin
        if (wr) wrn = 0; else rdn = 0;
      end
    end else if (c == dn) begin
      le = wr; ll = !wr;
    end else begin
      occ = 0;
    end
    return {cs, rdn, wrn, ad, oe, occ, le, ll, o};
  endfunction

  task automatic run_txn(input vec_t v);
    int s = sel ? 1 : 2, p = sel ? 1 : 4, h = sel ? 1 : 2, g = sel ? 1 : 3;
    int total = 2 * s + 2 * p + 2 * h + g + 1;
    sb_t e;
    e.is_rd = !v.sw; e.dato = v.exp_dato; e.err = v.exp_err;
    sb.push_back(e);
    start_write = v.sw; start_read = v.sr;
    direccion = v.addr; dato_escritura = v.data; rtc_val = v.rtc;
    for (int c = 1; c <= total + 1; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start_write = 0; start_read = 0;
        direccion = ~v.addr; dato_escritura = ~v.data;
      end
      if (v.poke != 0 && c == v.poke + 1) begin start_write = 0; start_read = 0; end
      check($sformatf("bus a=%h cycle %0d", v.addr, c), 32'(obs_bus()),
            32'(exp_bus(c, v.sw, v.addr, v.data, s, p, h, g)));
      if (obs_bus()[9] || obs_bus()[8]) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check($sformatf("done status a=%h", v.addr), 32'(obs_status()),
                32'({e.is_rd, e.dato, e.err}));
        end
      end
      if (v.poke != 0 && c == v.poke) begin
        if (v.poke_wr) start_write = 1; else start_read = 1;
      end
    end
    check("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    vecs[0] = '{1, 0, 8'h21, 8'h45, 8'h00, 0, 0, 8'h00, 0};
    vecs[1] = '{0, 1, 8'h41, 8'h00, 8'h37, 0, 0, 8'h37, 0};
    vecs[2] = '{0, 1, 8'h42, 8'h00, 8'h3A, 0, 0, 8'h3A, BCD_EN};
    vecs[3] = '{0, 1, 8'h43, 8'h00, 8'h59, 0, 0, 8'h59, 0};
    vecs[4] = '{1, 1, 8'h10, 8'hAA, 8'h66, 5, 0, 8'h59, 0};
    vecs[5] = '{1, 0, 8'h11, 8'hBB, 8'h00, 20, 1, 8'h59, 0};

    sel = 0; reset = 0;
    start_write = 0; start_read = 0;
    direccion = 0; dato_escritura = 0; rtc_val = 0;
    repeat (2) @(negedge clk);
    check("reset bus", 32'(obs_bus()), 32'(exp_bus(1000, 0, 0, 0, 2, 4, 2, 3)));
    check("reset status", 32'(obs_status()), 32'd0);
    reset = 1;
    @(negedge clk);

    foreach (vecs[i]) run_txn(vecs[i]);

    // Reset held two cycles during a write address pulse
    start_write = 1; direccion = 8'h55; dato_escritura = 8'h66;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start_write = 0;
      check($sformatf("pre-reset cycle %0d", c), 32'(obs_bus()),
            32'(exp_bus(c, 1, 8'h55, 8'h66, 2, 4, 2, 3)));
    end
    reset = 0;
    @(negedge clk);
    check("reset edge bus", 32'(obs_bus()), 32'(exp_bus(1000, 0, 0, 0, 2, 4, 2, 3)));
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    check("post-reset bus", 32'(obs_bus()), 32'(exp_bus(1000, 0, 0, 0, 2, 4, 2, 3)));
    check("post-reset status", 32'(obs_status()), 32'd0);

    // Minimum timing, back-to-back writes
    sel = 1;
    run_txn('{1, 0, 8'hF1, 8'h00, 8'h00, 0, 0, 8'h00, 0});
    run_txn('{1, 0, 8'hF0, 8'h02, 8'h00, 0, 0, 8'h00, 0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
